// File: rtl/mips_decode_mc.sv
// mips_decode_mc: multicycle control FSM for a MIPS ALU/load/store subset.
// Ports: clock, reset_n (async active-low); in_valid/in_ready accept handshake with
//        opcode/funct; alu_op, rd_src, alu_src2 datapath controls; mem_read/mem_write
//        data-memory strobes; writeenable register-file strobe; except pulses for an
//        illegal instruction; done pulses on the last cycle of every instruction.
module mips_decode_mc #(
  parameter int MEM_WAIT = 2,
  parameter bit EN_IMM = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       rd_src,
  output logic       alu_src2,
  output logic       mem_read,
  output logic       mem_write,
  output logic       writeenable,
  output logic       except,
  output logic       done
);
  typedef enum logic [2:0] {IDLE, EXEC, MEM, WB, EXC} state_t;
  state_t     r_state;
  logic [5:0] r_op;
  logic [5:0] r_fn;
  logic [3:0] r_cnt;
  logic       w_imm;
  logic       w_legal;
  logic       w_lw;
  logic       w_sw;
  logic       w_busy;
  // 000 flags an unknown R-type funct; every non-R opcode that reaches here is add unless logical
  function automatic logic [2:0] f_alu(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00)
      return fn == 6'h20 ? 3'b010 : fn == 6'h22 ? 3'b011 : fn == 6'h24 ? 3'b100 :
             fn == 6'h25 ? 3'b101 : fn == 6'h26 ? 3'b111 : fn == 6'h27 ? 3'b110 : 3'b000;
    return op == 6'h0c ? 3'b100 : op == 6'h0d ? 3'b101 : op == 6'h0e ? 3'b111 : 3'b010;
  endfunction
  assign w_imm    = opcode inside {6'h08, 6'h0c, 6'h0d, 6'h0e};
  assign w_legal  = (opcode == 6'h00 && f_alu(opcode, funct) != 3'b000) || (w_imm && EN_IMM) ||
                    opcode == 6'h23 || opcode == 6'h2b;
  assign w_lw     = r_op == 6'h23;
  assign w_sw     = r_op == 6'h2b;
  // datapath controls come only from the captured instruction, so they cannot follow the inputs
  assign w_busy   = r_state inside {EXEC, MEM, WB};
  assign in_ready = r_state == IDLE;
  assign alu_op   = w_busy ? f_alu(r_op, r_fn) : 3'b000;
  assign rd_src   = w_busy && r_op != 6'h00 && !w_sw;
  assign alu_src2 = w_busy && r_op != 6'h00;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_op        <= 6'h00;
      r_fn        <= 6'h00;
      r_cnt       <= 4'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      writeenable <= 1'b0;
      except      <= 1'b0;
      done        <= 1'b0;
    end else begin
      writeenable <= 1'b0;
      except      <= 1'b0;
      done        <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_op    <= opcode;
          r_fn    <= funct;
          r_state <= w_legal ? EXEC : EXC;
          except  <= !w_legal;
          done    <= !w_legal;
        end
        EXEC: if (w_lw || w_sw) begin
          r_state   <= MEM;
          r_cnt     <= 4'(MEM_WAIT);
          mem_read  <= w_lw;
          mem_write <= w_sw;
          done      <= w_sw && MEM_WAIT == 1;
        end else begin
          r_state     <= WB;
          writeenable <= 1'b1;
          done        <= 1'b1;
        end
        // done is registered, so a store raises it one edge before its final MEM cycle
        MEM: if (r_cnt <= 4'd1) begin
          r_state     <= w_lw ? WB : IDLE;
          mem_read    <= 1'b0;
          mem_write   <= 1'b0;
          writeenable <= w_lw;
          done        <= w_lw;
        end else begin
          r_cnt <= r_cnt - 4'd1;
          done  <= w_sw && r_cnt == 4'd2;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_decode_mc.sv
// tb_mips_decode_mc: random and directed checks of two decoder configurations against a cycle-list model.
module tb_mips_decode_mc;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] iv, rdy, rs, s2, mr, mw, we, ex, dn;
  logic [1:0][5:0] op, fn;
  logic [1:0][2:0] alu;
  int checks = 0;
  int failures = 0;
  localparam logic [10:0] IDLE_V = 11'h400;
  logic [10:0] seq [2][32];
  int len [2];
  int pos [2];
  logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
  always #5 clock = ~clock;

  mips_decode_mc #(.MEM_WAIT(3), .EN_IMM(1'b1)) u0 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(rdy[0]),
    .opcode(op[0]), .funct(fn[0]), .alu_op(alu[0]), .rd_src(rs[0]), .alu_src2(s2[0]),
    .mem_read(mr[0]), .mem_write(mw[0]), .writeenable(we[0]), .except(ex[0]), .done(dn[0]));
  mips_decode_mc #(.MEM_WAIT(1), .EN_IMM(1'b0)) u1 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(rdy[1]),
    .opcode(op[1]), .funct(fn[1]), .alu_op(alu[1]), .rd_src(rs[1]), .alu_src2(s2[1]),
    .mem_read(mr[1]), .mem_write(mw[1]), .writeenable(we[1]), .except(ex[1]), .done(dn[1]));

  task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [10:0] pack(input bit r, input logic [2:0] a, input bit d, input bit s,
      input bit rd, input bit wr, input bit w, input bit e, input bit f);
    return {r, a, d, s, rd, wr, w, e, f};
  endfunction

  function automatic logic [10:0] dut_v(input int k);
    return {rdy[k], alu[k], rs[k], s2[k], mr[k], mw[k], we[k], ex[k], dn[k]};
  endfunction

  function automatic logic [10:0] exp_v(input int k);
    return pos[k] < len[k] ? seq[k][pos[k]] : IDLE_V;
  endfunction

  // expected outputs of every cycle after acceptance, straight from the instruction class
  task automatic build(input int k, input logic [5:0] o, input logic [5:0] f);
    int kind = 0;
    int n = 0;
    int mwait = k == 0 ? 3 : 1;
    bit en = k == 0;
    logic [2:0] a = 3'b000;
    bit r = 0;
    bit s = 0;
    case (o)
      6'h00: begin
        case (f)
          6'h20: a = 3'b010;
          6'h22: a = 3'b011;
          6'h24: a = 3'b100;
          6'h25: a = 3'b101;
          6'h26: a = 3'b111;
          6'h27: a = 3'b110;
          default: a = 3'b000;
        endcase
        kind = a != 3'b000 ? 1 : 0;
      end
      6'h08, 6'h0c, 6'h0d, 6'h0e: if (en) begin
        a = o == 6'h08 ? 3'b010 : o == 6'h0c ? 3'b100 : o == 6'h0d ? 3'b101 : 3'b111;
        kind = 1; r = 1; s = 1;
      end
      6'h23: begin kind = 2; a = 3'b010; r = 1; s = 1; end
      6'h2b: begin kind = 3; a = 3'b010; r = 0; s = 1; end
      default: kind = 0;
    endcase
    if (kind == 0) begin
      seq[k][0] = pack(0, 3'b000, 0, 0, 0, 0, 0, 1, 1);
      n = 1;
    end else begin
      seq[k][n++] = pack(0, a, r, s, 0, 0, 0, 0, 0);
      if (kind >= 2)
        for (int i = 0; i < mwait; i++)
          seq[k][n++] = pack(0, a, r, s, kind == 2, kind == 3, 0, 0, kind == 3 && i == mwait - 1);
      if (kind != 3) seq[k][n++] = pack(0, a, r, s, 0, 0, 1, 0, 1);
    end
    len[k] = n;
    pos[k] = 0;
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin len[k] = 0; pos[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++)
        if (pos[k] < len[k]) pos[k]++;
        else if (iv[k]) build(k, op[k], fn[k]);
    end
  end

  always @(negedge clock)
    for (int k = 0; k < 2; k++) chk($sformatf("cycle u%0d", k), dut_v(k), exp_v(k));

  initial begin
    logic [10:0] cnt;
    iv = 2'b00;
    op = '0;
    fn = '0;
    repeat (2) @(negedge clock);
    chk("reset u0 outputs", dut_v(0), 11'h400);
    chk("reset u1 outputs", dut_v(1), 11'h400);
    reset_n = 1'b1;
    // add on u0
    @(negedge clock); iv[0] = 1; op[0] = 6'h00; fn[0] = 6'h20;
    @(negedge clock);
    chk("add exec alu_op", 11'(alu[0]), 11'd2);
    chk("add exec rd_src/alu_src2", 11'({rs[0], s2[0]}), 11'd0);
    chk("add exec done", 11'(dn[0]), 11'd0);
    iv[0] = 0;
    @(negedge clock); chk("add wb we/done", 11'({we[0], dn[0]}), 11'd3);
    @(negedge clock); chk("add ready after", 11'(rdy[0]), 11'd1);
    // lw on u0, MEM_WAIT=3; opcode changed after acceptance must be ignored
    @(negedge clock); iv[0] = 1; op[0] = 6'h23; fn[0] = 6'h15;
    @(negedge clock);
    chk("lw exec alu/rd_src/src2", 11'({alu[0], rs[0], s2[0]}), 11'b01011);
    iv[0] = 0; op[0] = 6'h2b;
    cnt = 0;
    for (int i = 2; i <= 5; i++) begin
      @(negedge clock);
      cnt = cnt + 11'(mr[0]);
      if (i == 5) chk("lw cycle5 we/done/mem_read", 11'({we[0], dn[0], mr[0]}), 11'b110);
    end
    chk("lw mem_read cycles", cnt, 11'd3);
    // sw on u1, MEM_WAIT=1
    @(negedge clock); iv[1] = 1; op[1] = 6'h2b; fn[1] = 6'h00;
    @(negedge clock); iv[1] = 0; chk("sw exec mem_write", 11'(mw[1]), 11'd0);
    @(negedge clock); chk("sw mem_write/done/we", 11'({mw[1], dn[1], we[1]}), 11'b110);
    @(negedge clock); chk("sw ready after", 11'(rdy[1]), 11'd1);
    // illegal funct then addi with EN_IMM=0 on u1
    @(negedge clock); iv[1] = 1; op[1] = 6'h00; fn[1] = 6'h3f;
    @(negedge clock);
    chk("bad funct except/done", 11'({ex[1], dn[1], we[1], mr[1], mw[1]}), 11'b11000);
    op[1] = 6'h08; fn[1] = 6'h00;
    @(negedge clock); chk("ready after except", 11'(rdy[1]), 11'd1);
    @(negedge clock);
    chk("addi disabled except/done", 11'({ex[1], dn[1], we[1], mr[1], mw[1]}), 11'b11000);
    iv[1] = 0;
    // reset in the second MEM cycle of a lw on u0
    @(negedge clock); iv[0] = 1; op[0] = 6'h23;
    @(negedge clock); iv[0] = 0;
    @(negedge clock);
    @(negedge clock); chk("lw mem2 mem_read", 11'(mr[0]), 11'd1);
    #2 reset_n = 1'b0;
    #1 chk("async reset outputs", dut_v(0), 11'h400);
    @(negedge clock); reset_n = 1'b1;
    cnt = 0;
    repeat (6) begin @(negedge clock); cnt = cnt + 11'(we[0]); end
    chk("no we after reset", cnt, 11'd0);
    // sub, or, xori back to back with in_valid held
    @(negedge clock); iv[0] = 1; op[0] = 6'h00; fn[0] = 6'h22;
    @(negedge clock); chk("b2b sub alu_op", 11'(alu[0]), 11'd3);
    @(negedge clock); chk("b2b sub done", 11'(dn[0]), 11'd1); fn[0] = 6'h25;
    @(negedge clock);
    @(negedge clock); chk("b2b or alu_op", 11'(alu[0]), 11'd5);
    @(negedge clock); chk("b2b or done", 11'(dn[0]), 11'd1); op[0] = 6'h0e; fn[0] = 6'h2a;
    @(negedge clock);
    @(negedge clock); chk("b2b xori alu_op", 11'(alu[0]), 11'd7); iv[0] = 0;
    @(negedge clock); chk("b2b xori done", 11'(dn[0]), 11'd1);
    // random traffic with occasional asynchronous resets
    repeat (4000) begin
      @(negedge clock);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
        iv[k] = $urandom_range(0, 3) != 0;
        case ($urandom_range(0, 9))
          0, 1, 2: op[k] = 6'h00;
          3: op[k] = 6'h08;
          4: op[k] = 6'h0c;
          5: op[k] = 6'h0d;
          6: op[k] = 6'h0e;
          7: op[k] = 6'h23;
          8: op[k] = 6'h2b;
          default: op[k] = 6'($urandom);
        endcase
        fn[k] = $urandom_range(0, 7) < 6 ? fl[$urandom_range(0, 5)] : 6'($urandom);
      end
    end
    @(negedge clock); iv = 2'b00;
    repeat (20) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
